muldiv_control: RTL and testbench

- Sequential successor to the decode-stage control unit.
- Decodes MULT/DIV (and optionally MULTU/DIVU) plus MFHI/MFLO, and launches the multi-cycle HI/LO unit in execute.
- Tracks the in-flight operation with a latency counter and stalls decode on HI/LO hazards.
- Sits beside the control unit in decode; its stall output feeds the pipeline hazard logic.

---
 rtl/muldiv_control_pkg.sv | 24 ++
 rtl/muldiv_decode.sv | 30 +++
 rtl/muldiv_control.sv | 90 +++++++++
 tb/tb_muldiv_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_control_pkg.sv
// rtl/muldiv_control_pkg.sv - MIPS opcode/funct constants and FSM encoding for the HI/LO control slice
package muldiv_control_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  typedef struct packed {
    logic is_muldiv;
    logic is_mf;
    logic is_div;
    logic is_signed;
  } muldiv_class_t;

endpackage

// File: rtl/muldiv_decode.sv
// rtl/muldiv_decode.sv - combinational MULT/DIV/MFHI/MFLO classifier
// MULDIV_UNSIGNED_EN adds MULTU/DIVU as unsigned muldiv operations.
module muldiv_decode
  import muldiv_control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_muldiv,
  output logic       is_mf,
  output logic       is_div,
  output logic       is_signed
);

  logic special;

  assign special = (opcode == OP_SPECIAL);
  assign is_mf   = special & ((funct == FN_MFHI) | (funct == FN_MFLO));

`ifdef MULDIV_UNSIGNED_EN
  assign is_muldiv = special & ((funct == FN_MULT) | (funct == FN_DIV) |
                                (funct == FN_MULTU) | (funct == FN_DIVU));
  assign is_div    = (funct == FN_DIV) | (funct == FN_DIVU);
  assign is_signed = (funct == FN_MULT) | (funct == FN_DIV);
`else
  assign is_muldiv = special & ((funct == FN_MULT) | (funct == FN_DIV));
  assign is_div    = (funct == FN_DIV);
  assign is_signed = 1'b1;
`endif

endmodule

// File: rtl/muldiv_control.sv
// rtl/muldiv_control.sv - decode-side launcher and hazard tracker for the multi-cycle HI/LO unit
// Optional MULDIV_UNSIGNED_EN enables MULTU/DIVU issue.
module muldiv_control
  import muldiv_control_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       valid_d,
  input  logic       flush_d,
  output logic       stall_d,
  output logic       start_e,
  output logic       is_div_e,
  output logic       signed_e,
  output logic       busy,
  output logic       hilo_we
);

  if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_lat_zero
    $error("muldiv_control: MULT_CYCLES and DIV_CYCLES must be at least 1");
  end
  if (MULT_CYCLES > 2**CNT_W || DIV_CYCLES > 2**CNT_W) begin : g_lat_wide
    $error("muldiv_control: latency does not fit the CNT_W-bit counter");
  end

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic             is_muldiv;
  logic             is_mf;
  logic             is_div;
  logic             is_signed;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_load;
  logic             qual;
  logic             issue;
  logic             hilo_next;

  muldiv_decode u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .is_muldiv (is_muldiv),
    .is_mf     (is_mf),
    .is_div    (is_div),
    .is_signed (is_signed)
  );

  assign busy     = (state == BUSY);
  assign qual     = valid_d & ~flush_d;
  assign stall_d  = qual & (is_muldiv | is_mf) & busy;
  assign issue    = qual & is_muldiv & ~busy;
  assign lat_load = is_div ? DIV_LOAD : MULT_LOAD;

  // hilo_we is registered, so it is armed one cycle before the counter reaches zero
  assign hilo_next = issue ? (lat_load == '0)
                           : (busy & (cnt == CNT_W'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      start_e  <= 1'b0;
      hilo_we  <= 1'b0;
      is_div_e <= 1'b0;
      signed_e <= 1'b0;
    end else begin
      start_e <= issue;
      hilo_we <= hilo_next;
      if (issue) begin
        state    <= BUSY;
        cnt      <= lat_load;
        is_div_e <= is_div;
        signed_e <= is_signed;
      end else if (state == BUSY) begin
        if (cnt == '0) begin
          state <= IDLE;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_control.sv
// tb/tb_muldiv_control.sv - randomized and directed self-checking bench for muldiv_control
module tb_muldiv_control;

  localparam int MC = 4;
  localparam int DC = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       valid_d = 1'b0;
  logic       flush_d = 1'b0;
  logic       stall_d, start_e, is_div_e, signed_e, busy, hilo_we;

  muldiv_control #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .opcode   (opcode),
    .funct    (funct),
    .valid_d  (valid_d),
    .flush_d  (flush_d),
    .stall_d  (stall_d),
    .start_e  (start_e),
    .is_div_e (is_div_e),
    .signed_e (signed_e),
    .busy     (busy),
    .hilo_we  (hilo_we)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference classification straight from the instruction set tables
  function automatic bit m_muldiv(input logic [5:0] op, input logic [5:0] fn);
    if (op != 6'h00) return 1'b0;
    if (fn == 6'h18 || fn == 6'h1a) return 1'b1;
`ifdef MULDIV_UNSIGNED_EN
    if (fn == 6'h19 || fn == 6'h1b) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit m_mf(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn == 6'h10 || fn == 6'h12);
  endfunction

  function automatic bit m_div(input logic [5:0] fn);
    return (fn == 6'h1a || fn == 6'h1b);
  endfunction

  function automatic bit m_sgn(input logic [5:0] fn);
`ifdef MULDIV_UNSIGNED_EN
    return (fn == 6'h18 || fn == 6'h1a);
`else
    return 1'b1;
`endif
  endfunction

  // Model: an op issued in cycle t with latency L is busy over t+1..t+L
  int cyc = 0;
  bit have_op = 0;
  int t_iss = 0;
  int lat = 0;
  bit x_div = 0;
  bit x_sgn = 0;
  bit e_busy, e_start, e_hwe, e_stall;

  int n_start = 0, n_busy = 0, n_hilo = 0;
  int last_start = 0, last_hilo = 0;

  always @(negedge clock) begin
    cyc++;
    e_busy  = have_op && cyc >= t_iss + 1 && cyc <= t_iss + lat;
    e_start = have_op && cyc == t_iss + 1;
    e_hwe   = have_op && cyc == t_iss + lat;
    e_stall = valid_d && !flush_d && (m_muldiv(opcode, funct) || m_mf(opcode, funct)) && e_busy;
    chk("busy", busy, e_busy);
    chk("start_e", start_e, e_start);
    chk("hilo_we", hilo_we, e_hwe);
    chk("stall_d", stall_d, e_stall);
    chk("is_div_e", is_div_e, x_div);
    chk("signed_e", signed_e, x_sgn);
    if (start_e === 1'b1) begin n_start++; last_start = cyc; end
    if (busy === 1'b1) n_busy++;
    if (hilo_we === 1'b1) begin n_hilo++; last_hilo = cyc; end
    if (reset) begin
      have_op = 0;
      x_div = 0;
      x_sgn = 0;
    end else if (valid_d && !flush_d && m_muldiv(opcode, funct) && !e_busy) begin
      have_op = 1;
      t_iss = cyc;
      lat = m_div(funct) ? DC : MC;
      x_div = m_div(funct);
      x_sgn = m_sgn(funct);
    end
  end

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic v, input logic f);
    @(posedge clock);
    #1;
    opcode = op;
    funct = fn;
    valid_d = v;
    flush_d = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(6'h09, 6'h00, 1'b1, 1'b0);
  endtask

  // Holds an instruction in decode until it is no longer stalled; returns stall cycles seen
  task automatic hold_until_go(input logic [5:0] fn, output int nst);
    nst = 0;
    drive(6'h00, fn, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if (stall_d !== 1'b1) return;
      nst++;
    end
    chk("hold_bound", 32'd1, 32'd0);
  endtask

  int s_start, s_busy, s_hilo, nst;
  logic [5:0] rfn;

  initial begin
    idle(3);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", start_e, 1'b0);
    chk("rst_hwe", hilo_we, 1'b0);
    chk("rst_sgn", signed_e, 1'b0);
    idle(5);
    #1;
    chk("addiu_stall", stall_d, 1'b0);

    // MULT: one start, four busy cycles, hilo_we three cycles after start_e
    s_start = n_start; s_busy = n_busy; s_hilo = n_hilo;
    drive(6'h00, 6'h18, 1'b1, 1'b0);
    idle(8);
    chk("mult_starts", n_start - s_start, 1);
    chk("mult_busy", n_busy - s_busy, 4);
    chk("mult_hwe", n_hilo - s_hilo, 1);
    chk("mult_hwe_lag", last_hilo - last_start, 3);
    chk("mult_div_e", is_div_e, 1'b0);
    chk("mult_sgn_e", signed_e, 1'b1);

    // DIV then MFLO: MFLO stalls for the full 32-cycle divide
    drive(6'h00, 6'h1a, 1'b1, 1'b0);
    hold_until_go(6'h12, nst);
    chk("div_mflo_stalls", nst, 32);
    idle(3);

    // MULT then DIV back-to-back
    drive(6'h00, 6'h18, 1'b1, 1'b0);
    hold_until_go(6'h1a, nst);
    chk("mult_div_stalls", nst, 4);
    idle(1);
    #1;
    chk("b2b_start", start_e, 1'b1);
    chk("b2b_div_e", is_div_e, 1'b1);
    idle(40);

    // Reset two cycles into a DIV abandons it
    s_hilo = n_hilo;
    drive(6'h00, 6'h1a, 1'b1, 1'b0);
    idle(1);
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock); #1;
    chk("rst_mid_busy", busy, 1'b0);
    idle(40);
    chk("rst_mid_nohwe", n_hilo - s_hilo, 0);
    s_start = n_start;
    drive(6'h00, 6'h18, 1'b1, 1'b0);
    idle(2);
    chk("rst_mid_mult", n_start - s_start, 1);
    idle(6);

    // Flushed DIV does nothing
    s_start = n_start; s_busy = n_busy;
    drive(6'h00, 6'h1a, 1'b1, 1'b1);
    idle(4);
    chk("flush_start", n_start - s_start, 0);
    chk("flush_busy", n_busy - s_busy, 0);

    // DIVU depends on the optional unsigned support
    s_start = n_start; s_busy = n_busy;
    drive(6'h00, 6'h1b, 1'b1, 1'b0);
    idle(1);
    #1;
`ifdef MULDIV_UNSIGNED_EN
    chk("divu_sgn", signed_e, 1'b0);
    idle(40);
    chk("divu_busy", n_busy - s_busy, 32);
`else
    idle(40);
    chk("divu_ignored", n_start - s_start, 0);
`endif

    // Randomized phase, checked cycle by cycle by the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(9))
        0: rfn = 6'h18;
        1: rfn = 6'h19;
        2: rfn = 6'h1a;
        3: rfn = 6'h1b;
        4: rfn = 6'h10;
        5: rfn = 6'h12;
        6: rfn = 6'h21;
        default: rfn = 6'($urandom);
      endcase
      drive(($urandom_range(7) == 0) ? 6'($urandom) : 6'h00, rfn,
            $urandom_range(9) != 0, $urandom_range(9) == 0);
      reset = ($urandom_range(199) == 0);
    end
    reset = 1'b0;
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
